rr_pop_sched: RTL and testbench

- Downstream drain stage for the multi-FIFO static circular buffer. It snoops buffer pushes and keeps a shadow occupancy count for each FIFO.
- Picks a non-empty FIFO round-robin, issues the buffer pop, and registers the popped word into a one-entry valid/ready output slot.
- Exports per-FIFO full flags so the upstream producer can gate its pushes.

---
 rtl/rr_pop_sched.sv | 149 ++++++++++++++
 tb/tb_rr_pop_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_pop_sched.sv
`default_nettype none
// ============================================================================
// rr_pop_sched : round-robin drain stage for a multi-FIFO circular buffer;
//                shadows per-FIFO occupancy and pops into a valid/ready slot.
// Revision     : 1.0
// ============================================================================
module rr_pop_sched #(
  parameter  int NUMELEM = 4,
  parameter  int BITDATA = 4,
  parameter  int NUMFIFO = 8,
  localparam int BITFIFO = $clog2(NUMFIFO),
  localparam int BITELEM = $clog2(NUMELEM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [BITFIFO-1:0] pu_prt,
  output logic               pop,
  output logic [BITFIFO-1:0] po_prt,
  input  logic [BITDATA-1:0] po_dout,
  output logic [NUMFIFO-1:0] full,
  output logic               out_vld,
  output logic [BITFIFO-1:0] out_prt,
  output logic [BITDATA-1:0] out_data,
  input  logic               out_rdy,
  output logic               ovf_err
);

  localparam int                 BITCNT     = BITELEM + 1;
  localparam logic [BITCNT-1:0]  C_CNT_FULL = BITCNT'(NUMELEM);
  localparam logic [BITCNT-1:0]  C_CNT_ONE  = BITCNT'(1);
  localparam logic [BITFIFO-1:0] C_RR_INIT  = BITFIFO'(NUMFIFO - 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  slot_state_t          state_q;
  logic [BITCNT-1:0]    cnt_q [NUMFIFO];
  logic [BITCNT-1:0]    cnt_d [NUMFIFO];
  logic [NUMFIFO-1:0]   req;
  logic [NUMFIFO-1:0]   ovf_hit;
  logic [BITFIFO-1:0]   rr_last_q;
  logic [BITFIFO-1:0]   sel;
  logic [BITFIFO-1:0]   idx;
  logic                 found;
  logic                 can_load;
  logic                 pop_w;
  logic [BITFIFO-1:0]   out_prt_q;
  logic [BITDATA-1:0]   out_data_q;
  logic                 ovf_q;

  assign can_load = (state_q == S_EMPTY) || out_rdy;
  assign pop_w    = can_load && (|req) && !rst;

  // Rotating search starting just after the last served FIFO; the index
  // arithmetic wraps naturally because NUMFIFO is a power of two.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUMFIFO; k++) begin
      idx = rr_last_q + BITFIFO'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign pop    = pop_w;
  assign po_prt = pop_w ? sel : '0;

  generate
    for (genvar i = 0; i < NUMFIFO; i++) begin : g_cnt
      logic inc;
      logic dec;

      assign inc        = push && (pu_prt == BITFIFO'(i));
      assign dec        = pop_w && (sel == BITFIFO'(i));
      assign req[i]     = (cnt_q[i] != '0);
      assign full[i]    = (cnt_q[i] == C_CNT_FULL);
      assign ovf_hit[i] = inc && !dec && (cnt_q[i] == C_CNT_FULL);

      // A push into a full FIFO is dropped from the count; only the error flag records it.
      always_comb begin
        cnt_d[i] = cnt_q[i];
        if (inc && !dec && (cnt_q[i] != C_CNT_FULL)) begin
          cnt_d[i] = cnt_q[i] + C_CNT_ONE;
        end else if (dec && !inc) begin
          cnt_d[i] = cnt_q[i] - C_CNT_ONE;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      out_prt_q  <= '0;
      out_data_q <= '0;
      rr_last_q  <= C_RR_INIT;
      ovf_q      <= 1'b0;
    end else begin
      if (|ovf_hit) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        S_EMPTY: begin
          if (pop_w) begin
            state_q    <= S_FULL;
            out_data_q <= po_dout;
            out_prt_q  <= sel;
            rr_last_q  <= sel;
          end
        end
        S_FULL: begin
          // A pop here implies out_rdy, so the old word leaves as the new one lands.
          if (pop_w) begin
            out_data_q <= po_dout;
            out_prt_q  <= sel;
            rr_last_q  <= sel;
          end else if (out_rdy) begin
            state_q <= S_EMPTY;
          end
        end
        default: begin
          state_q <= S_EMPTY;
        end
      endcase
    end
  end

  assign out_vld  = (state_q == S_FULL);
  assign out_prt  = out_prt_q;
  assign out_data = out_data_q;
  assign ovf_err  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_pop_sched.sv
`default_nettype none
// ============================================================================
// tb_rr_pop_sched : directed and random stimulus for rr_pop_sched, checked
//                   against a queue-based reference model and a buffer stand-in.
// Revision        : 1.0
// ============================================================================
module tb_rr_pop_sched;

  localparam int NUMELEM = 4;
  localparam int BITDATA = 4;
  localparam int NUMFIFO = 8;
  localparam int BITFIFO = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               push = 1'b0;
  logic [BITFIFO-1:0] pu_prt = '0;
  logic [BITDATA-1:0] pu_data = '0;
  logic               out_rdy = 1'b0;
  logic               pop;
  logic [BITFIFO-1:0] po_prt;
  logic [BITDATA-1:0] po_dout;
  logic [NUMFIFO-1:0] full;
  logic               out_vld;
  logic [BITFIFO-1:0] out_prt;
  logic [BITDATA-1:0] out_data;
  logic               ovf_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_pop_sched #(.NUMELEM(NUMELEM), .BITDATA(BITDATA), .NUMFIFO(NUMFIFO)) dut (
    .clk(clk), .rst(rst), .push(push), .pu_prt(pu_prt), .pop(pop), .po_prt(po_prt),
    .po_dout(po_dout), .full(full), .out_vld(out_vld), .out_prt(out_prt),
    .out_data(out_data), .out_rdy(out_rdy), .ovf_err(ovf_err)
  );

  // Stand-in for the circular buffer: stores pushed words, presents the head of po_prt.
  logic [BITDATA-1:0] mem [NUMFIFO][NUMELEM];
  logic [1:0]         wp [NUMFIFO];
  logic [1:0]         rp [NUMFIFO];
  int                 bcnt [NUMFIFO];
  logic               b_push_ok;

  assign b_push_ok = push && ((bcnt[pu_prt] != NUMELEM) || (pop && po_prt == pu_prt));
  assign po_dout   = mem[po_prt][rp[po_prt]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < NUMFIFO; f++) begin
        wp[f]   <= '0;
        rp[f]   <= '0;
        bcnt[f] <= 0;
      end
    end else begin
      for (int f = 0; f < NUMFIFO; f++) begin
        bcnt[f] <= bcnt[f] + ((b_push_ok && pu_prt == f) ? 1 : 0) - ((pop && po_prt == f) ? 1 : 0);
      end
      if (b_push_ok) begin
        mem[pu_prt][wp[pu_prt]] <= pu_data;
        wp[pu_prt]              <= wp[pu_prt] + 2'd1;
      end
      if (pop) begin
        rp[po_prt] <= rp[po_prt] + 2'd1;
      end
    end
  end

  // Reference model: per-FIFO queues of outstanding words plus the slot contents.
  int                 refcnt [NUMFIFO];
  logic [BITDATA-1:0] refq [NUMFIFO][$];
  int                 last_pop;
  bit                 m_vld;
  int                 m_prt;
  logic [BITDATA-1:0] m_data;
  bit                 m_ovf;
  int                 popseq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUMFIFO; i++) begin
      refcnt[i] = 0;
      refq[i].delete();
    end
    last_pop = NUMFIFO - 1;
    m_vld    = 1'b0;
    m_prt    = 0;
    m_data   = '0;
    m_ovf    = 1'b0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model across the edge.
  task automatic tick();
    int         sel;
    int         cpre;
    bit         any;
    bit         exp_pop;
    logic [7:0] exp_full;
    @(negedge clk);
    any = 1'b0;
    sel = 0;
    for (int k = 1; k <= NUMFIFO; k++) begin
      int j;
      j = (last_pop + k) % NUMFIFO;
      if (!any && refcnt[j] > 0) begin
        sel = j;
        any = 1'b1;
      end
    end
    exp_pop = (!m_vld || out_rdy) && any && !rst;
    for (int i = 0; i < NUMFIFO; i++) exp_full[i] = (refcnt[i] == NUMELEM);
    chk("pop", pop, exp_pop);
    chk("po_prt", po_prt, exp_pop ? sel : 0);
    chk("full", full, exp_full);
    chk("out_vld", out_vld, m_vld);
    chk("out_prt", out_prt, m_prt);
    chk("out_data", out_data, m_data);
    chk("ovf_err", ovf_err, m_ovf);
    @(posedge clk);
    if (!rst) begin
      cpre = refcnt[pu_prt];
      if (exp_pop) begin
        refcnt[sel]--;
        m_data   = refq[sel].pop_front();
        m_prt    = sel;
        m_vld    = 1'b1;
        last_pop = sel;
        popseq.push_back(sel);
      end else if (m_vld && out_rdy) begin
        m_vld = 1'b0;
      end
      if (push) begin
        if (cpre == NUMELEM && !(exp_pop && sel == pu_prt)) begin
          m_ovf = 1'b1;
        end else begin
          refcnt[pu_prt]++;
          refq[pu_prt].push_back(pu_data);
        end
      end
    end
    #1;
  endtask

  task automatic do_push(input int p, input int d);
    push    = 1'b1;
    pu_prt  = BITFIFO'(p);
    pu_data = BITDATA'(d);
    tick();
    push = 1'b0;
  endtask

  initial begin
    int exp_rr [6];
    exp_rr = '{7, 0, 2, 5, 0, 2};
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single word through FIFO 3.
    out_rdy = 1'b1;
    do_push(3, 'hA);
    chk("sw_pop", pop, 1);
    chk("sw_po_prt", po_prt, 3);
    tick();
    chk("sw_out_vld", out_vld, 1);
    chk("sw_out_prt", out_prt, 3);
    chk("sw_out_data", out_data, 'hA);
    tick();
    chk("sw_drained", out_vld, 0);
    chk("sw_full", full, 0);

    // Round-robin order with wrap.
    popseq.delete();
    out_rdy = 1'b0;
    do_push(7, 'h7);
    do_push(0, 'h1);
    do_push(2, 'h2);
    do_push(5, 'h3);
    out_rdy = 1'b1;
    tick();
    tick();
    do_push(0, 'h4);
    do_push(2, 'h5);
    repeat (3) tick();
    chk("rr_len", popseq.size(), 6);
    for (int i = 0; i < 6; i++) chk("rr_order", popseq[i], exp_rr[i]);

    // Backpressure on FIFO 1.
    popseq.delete();
    out_rdy = 1'b0;
    do_push(1, 'h1);
    do_push(1, 'h2);
    do_push(1, 'h3);
    repeat (3) tick();
    chk("bp_one_pop", popseq.size(), 1);
    chk("bp_hold_data", out_data, 'h1);
    out_rdy = 1'b1;
    tick();
    chk("bp_data2", out_data, 'h2);
    tick();
    chk("bp_data3", out_data, 'h3);
    tick();
    chk("bp_empty", out_vld, 0);

    // Fill FIFO 6 behind a stalled slot, then overflow it.
    out_rdy = 1'b0;
    do_push(0, 'hF);
    tick();
    for (int i = 0; i < NUMELEM; i++) do_push(6, i + 8);
    chk("ovf_full6", full[6], 1);
    chk("ovf_clear", ovf_err, 0);
    do_push(6, 'hE);
    chk("ovf_set", ovf_err, 1);
    chk("ovf_full6_hold", full[6], 1);
    out_rdy = 1'b1;
    do_push(6, 'hD);
    out_rdy = 1'b0;
    chk("pushpop_full6", full[6], 1);
    tick();
    chk("ovf_sticky", ovf_err, 1);

    // Asynchronous reset mid-transfer.
    chk("pre_rst_vld", out_vld, 1);
    rst = 1'b1;
    #1;
    chk("rst_vld", out_vld, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_full", full, 0);
    chk("rst_pop", pop, 0);
    chk("rst_data", out_data, 0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();

    // Random soak.
    for (int c = 0; c < 3000; c++) begin
      int p;
      p       = $urandom_range(0, NUMFIFO - 1);
      push    = ($urandom_range(0, 3) != 0) && (refcnt[p] < NUMELEM);
      pu_prt  = BITFIFO'(p);
      pu_data = BITDATA'($urandom);
      out_rdy = (c % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end
    push    = 1'b0;
    out_rdy = 1'b1;
    repeat (40) tick();
    chk("drain_vld", out_vld, 0);
    chk("drain_full", full, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
